alu_issue: RTL and testbench
============================

# alu_issue

Execute-stage initiator for the combinational ALU. It accepts one decoded RV32I register/immediate ALU instruction per cycle over a valid/ready handshake and translates funct3/funct7 into the 3-bit ALU op. It drives the ALU operands, captures the ALU result into a one-entry output register and presents it to writeback over a second valid/ready handshake. It sits between decode and writeback and also keeps a retired-instruction counter.

## Interface
- No parameters. Data width is fixed at 32, destination index at 5, ALU op at 3.
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  block can accept this cycle
- in_funct3  in  3  instruction funct3
- in_funct7_5  in  1  instruction bit 30
- in_is_imm  in  1  1 = OP-IMM form (B operand is in_imm), 0 = OP form (B is in_rs2_val)
- in_rs1_val  in  32  operand A
- in_rs2_val  in  32  register operand B
- in_imm  in  32  sign-extended immediate
- in_rd  in  5  destination register index
- alu_op  out  3  op to ALU: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_c  in  32  ALU result, combinational from alu_op/alu_a/alu_b
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writeback accepts
- out_rd  out  5  destination index
- out_data  out  32  result to write
- out_illegal  out  1  entry came from an unsupported funct3
- retired  out  32  count of completed output handshakes

## Operation
- Decode from in_funct3, combinational:
  - 000 → ADD, or SUB when in_funct7_5=1 and in_is_imm=0. ADDI with bit 30 set is still ADD.
  - 111 → AND.
  - 110 → OR.
  - 100 → XOR.
  - 001 → SLL.
  - 101 → SRA when in_funct7_5=1, else SRL. This applies to both forms.
  - 010 and 011 (SLT/SLTU) → illegal. The ALU does not support them.
- Operand drive: alu_a = in_rs1_val; alu_b = in_is_imm ? in_imm : in_rs2_val. The ALU uses only alu_b[4:0] for shifts, so imm[11:5] is don't-care for shifts.
- Illegal decode: alu_op = ADD. The captured out_data is forced to 0 and out_illegal=1. The entry still flows to writeback; writeback decides whether to trap.
- in_rd = 0: the entry is captured and retired normally, but out_data is forced to 0.
- Accept: fires when in_valid && in_ready. On that edge the block captures out_data (alu_c, or 0 per the rules above), out_rd, out_illegal, and sets out_valid=1.
- Buffer: a single entry. in_ready = !out_valid || out_ready, which is combinational pass-through of out_ready.
- Drain: on out_valid && out_ready, retired increments by 1 (wraps from 0xFFFFFFFF to 0). out_valid clears unless a new accept happens on the same edge.
- Simultaneous drain and accept: the new entry replaces the old one and out_valid stays 1. Throughput is one instruction per cycle.
- When out_valid=1 and out_ready=0: the held entry (out_rd/out_data/out_illegal) stays stable and in_ready=0.
- alu_op/alu_a/alu_b are driven from the in_* fields every cycle, regardless of in_valid.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N is visible on out_* after edge N.
- Reset (asynchronous, takes effect immediately): out_valid=0, out_rd=0, out_data=0, out_illegal=0, retired=0. in_ready=1 during and after reset.
- Reset asserted mid-operation discards the buffered entry without counting it.
- No combinational path from in_valid to in_ready.
- The only combinational input→output paths are:
  - out_ready → in_ready
  - in_* → alu_*

## Test plan
- ADD/SUB: rs1=5, rs2=3, funct3=000, is_imm=0, funct7_5=1, rd=4 → alu_op=1; next cycle out_valid=1, out_data=2, out_rd=4. Repeat with funct7_5=0 → out_data=8.
- ADDI with bit 30 set: is_imm=1, funct7_5=1, imm=0xFFFFFFFF, rs1=1 → alu_op=0, out_data=0.
- SRAI vs SRLI: rs1=0x80000000, imm=4, funct3=101. With funct7_5=1 → out_data=0xF8000000. With funct7_5=0 → out_data=0x08000000.
- Illegal and x0: funct3=010 → out_illegal=1, out_data=0. Then ADD with rd=0, rs1=7 → out_data=0. retired advances by 1 per handshake.
- Backpressure: hold out_ready=0 with a valid entry → in_ready=0 and the entry stays stable for 5 cycles. Then stream 10 instructions with out_ready=1 → one result per cycle, in order, retired=10 plus any prior count.
- Reset mid-stream: assert rst while out_valid=1 → out_valid=0 and retired=0 immediately. After release the first accepted instruction appears 1 cycle later.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: execute-stage initiator for the combinational ALU.
// Decodes RV32I OP/OP-IMM funct3/funct7 into the ALU op. It drives the ALU
// operands and captures the result into a one-entry output buffer. That
// buffer is presented to writeback over a valid/ready handshake. The block
// also counts every completed writeback handshake.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  // decode side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic        in_is_imm,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rd,
  // external combinational ALU
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_c,
  // writeback side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } alu_op_e;

  alu_op_e     op;
  logic        illegal;
  logic        accept;
  logic        drain;

  logic        out_valid_q,   out_valid_d;
  logic [4:0]  out_rd_q,      out_rd_d;
  logic [31:0] out_data_q,    out_data_d;
  logic        out_illegal_q, out_illegal_d;
  logic [31:0] retired_q,     retired_d;

  // Decode funct3/funct7 into the ALU op. SLT/SLTU are unsupported and flagged.
  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    case (in_funct3)
      3'b000:  op = (in_funct7_5 && !in_is_imm) ? OP_SUB : OP_ADD;
      3'b111:  op = OP_AND;
      3'b110:  op = OP_OR;
      3'b100:  op = OP_XOR;
      3'b001:  op = OP_SLL;
      3'b101:  op = in_funct7_5 ? OP_SRA : OP_SRL;
      default: begin
        op      = OP_ADD;
        illegal = 1'b1;
      end
    endcase
  end

  assign alu_op = op;
  assign alu_a  = in_rs1_val;
  assign alu_b  = in_is_imm ? in_imm : in_rs2_val;

  // The buffer frees up in the same cycle that writeback drains it, so out_ready
  // passes straight through to in_ready. This keeps one instruction per cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  // Next-state for the output entry and the retire counter.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_rd_d      = out_rd_q;
    out_data_d    = out_data_q;
    out_illegal_d = out_illegal_q;
    retired_d     = retired_q;
    if (drain) begin
      out_valid_d = 1'b0;
      retired_d   = retired_q + 32'd1;
    end
    if (accept) begin
      out_valid_d   = 1'b1;
      out_rd_d      = in_rd;
      out_illegal_d = illegal;
      out_data_d    = (illegal || (in_rd == 5'd0)) ? '0 : alu_c;
    end
  end

  // State registers. Reset discards any buffered entry without counting it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_data_q    <= '0;
      out_illegal_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_rd_q      <= out_rd_d;
      out_data_q    <= out_data_d;
      out_illegal_q <= out_illegal_d;
      retired_q     <= retired_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rd      = out_rd_q;
  assign out_data    = out_data_q;
  assign out_illegal = out_illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue. A reference decoder predicts each
// accepted instruction, the prediction is queued, and it is compared when the
// entry is presented to writeback.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        in_is_imm;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_illegal;
  logic [31:0] retired;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        pend;
  logic        mv;
  logic [31:0] ret_m;

  always #5 clk = ~clk;

  // Environment ALU, driven by the op code the DUT presents.
  always_comb begin
    case (alu_op)
      3'd0:    alu_c = alu_a + alu_b;
      3'd1:    alu_c = alu_a - alu_b;
      3'd2:    alu_c = alu_a & alu_b;
      3'd3:    alu_c = alu_a | alu_b;
      3'd4:    alu_c = alu_a ^ alu_b;
      3'd5:    alu_c = alu_a << alu_b[4:0];
      3'd6:    alu_c = alu_a >> alu_b[4:0];
      default: alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
    endcase
  end

  alu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_imm(in_is_imm),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_illegal(out_illegal), .retired(retired)
  );

  // Architectural result of an RV32I ALU instruction, computed from the fields.
  function automatic ent_t ref_ent(input logic [2:0] f3, input logic f7, input logic im,
                                   input logic [31:0] a, input logic [31:0] r2,
                                   input logic [31:0] imm, input logic [4:0] rd);
    ent_t        e;
    logic [31:0] b;
    b      = im ? imm : r2;
    e.rd   = rd;
    e.ill  = 1'b0;
    case (f3)
      3'b000:  e.data = (f7 && !im) ? a - b : a + b;
      3'b111:  e.data = a & b;
      3'b110:  e.data = a | b;
      3'b100:  e.data = a ^ b;
      3'b001:  e.data = a << b[4:0];
      3'b101:  e.data = f7 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      default: begin e.data = 32'd0; e.ill = 1'b1; end
    endcase
    if (e.ill || rd == 5'd0) e.data = 32'd0;
    return e;
  endfunction

  task automatic apply(input logic v, input logic [2:0] f3, input logic f7, input logic im,
                       input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [4:0] rd);
    in_valid    = v;
    in_funct3   = f3;
    in_funct7_5 = f7;
    in_is_imm   = im;
    in_rs1_val  = a;
    in_rs2_val  = r2;
    in_imm      = imm;
    in_rd       = rd;
    pend        = ref_ent(f3, f7, im, a, r2, imm, rd);
  endtask

  // Advance one clock and update the model, then stop at the following falling edge.
  task automatic step();
    logic acc;
    logic drn;
    @(posedge clk);
    acc = in_valid && (!mv || out_ready);
    drn = mv && out_ready;
    if (drn) begin
      void'(exp_q.pop_front());
      ret_m = ret_m + 32'd1;
    end
    if (acc) exp_q.push_back(pend);
    mv = acc || (mv && !out_ready);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    apply(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    mv = 1'b0; ret_m = 32'd0; exp_q.delete();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({out_valid, out_rd, out_data, out_illegal, retired} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b rd=%0d d=%h ill=%0b ret=%0d, want all zero",
               out_valid, out_rd, out_data, out_illegal, retired);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    logic [2:0] want_op [2] = '{3'd1, 3'd0};
    logic       f7s     [2] = '{1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 3'b000, f7s[i], 1'b0, 32'd5, 32'd3, 32'd0, 5'd4);
      #1;
      n_chk++;
      if (alu_op !== want_op[i] || alu_a !== 32'd5 || alu_b !== 32'd3) begin
        n_fail++;
        $display("FAIL add_sub_alu_drive[%0d]: got op=%0d a=%0d b=%0d want op=%0d a=5 b=3",
                 i, alu_op, alu_a, alu_b, want_op[i]);
      end
      step();
      apply(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
      n_chk++;
      if (out_valid !== 1'b1 || exp_q.size() != 1 ||
          {out_rd, out_data, out_illegal} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL add_sub_result[%0d]: got v=%b rd=%0d d=%0d ill=%b want rd=4 d=%0d",
                 i, out_valid, out_rd, out_data, out_illegal, (i == 0) ? 2 : 8);
      end
      step();
      n_chk++;
      if (out_valid !== 1'b0 || retired !== ret_m) begin
        n_fail++;
        $display("FAIL add_sub_drain[%0d]: got v=%b ret=%0d want v=0 ret=%0d",
                 i, out_valid, retired, ret_m);
      end
    end
  endtask

  task automatic test_imm_forms();
    // ADDI with bit 30 set, SRAI, SRLI
    logic [2:0]  f3s  [3] = '{3'b000, 3'b101, 3'b101};
    logic [31:0] rs1s [3] = '{32'd1, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] imms [3] = '{32'hFFFF_FFFF, 32'd4, 32'd4};
    logic        f7s  [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0]  ops  [3] = '{3'd0, 3'd7, 3'd6};
    logic [31:0] want [3] = '{32'd0, 32'hF800_0000, 32'h0800_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, f3s[i], f7s[i], 1'b1, rs1s[i], 32'h1234_5678, imms[i], 5'd9);
      #1;
      n_chk++;
      if (alu_op !== ops[i] || alu_b !== imms[i]) begin
        n_fail++;
        $display("FAIL imm_alu_drive[%0d]: got op=%0d b=%h want op=%0d b=%h",
                 i, alu_op, alu_b, ops[i], imms[i]);
      end
      step();
      apply(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== want[i] || out_rd !== 5'd9 || out_illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL imm_result[%0d]: got v=%b d=%h rd=%0d ill=%b want v=1 d=%h rd=9 ill=0",
                 i, out_valid, out_data, out_rd, out_illegal, want[i]);
      end
      step();
    end
  endtask

  task automatic test_illegal_x0();
    logic [31:0] r0;
    out_ready = 1'b1;
    r0 = ret_m;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: apply(1'b1, 3'b010, 1'b0, 1'b0, 32'd9, 32'd1, 32'd0, 5'd3);
        1: apply(1'b1, 3'b011, 1'b0, 1'b1, 32'd9, 32'd1, 32'd5, 5'd6);
        default: apply(1'b1, 3'b000, 1'b0, 1'b0, 32'd7, 32'd2, 32'd0, 5'd0);
      endcase
      #1;
      if (i < 2) begin
        n_chk++;
        if (alu_op !== 3'd0) begin
          n_fail++; $display("FAIL illegal_op[%0d]: got %0d want 0", i, alu_op);
        end
      end
      step();
      apply(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 32'd0 || out_illegal !== (i < 2) ||
          exp_q.size() != 1 || {out_rd, out_data, out_illegal} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL illegal_x0[%0d]: got v=%b d=%h ill=%b rd=%0d want d=0 ill=%0b",
                 i, out_valid, out_data, out_illegal, out_rd, (i < 2));
      end
      step();
      n_chk++;
      if (retired !== r0 + 32'(i + 1)) begin
        n_fail++;
        $display("FAIL illegal_x0_retired[%0d]: got %0d want %0d", i, retired, r0 + 32'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    ent_t        held;
    logic [31:0] r0;
    logic [2:0]  f3;
    out_ready = 1'b0;
    apply(1'b1, 3'b110, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 5'd17);
    held = pend;
    step();
    // a second instruction waits at the input and must not be taken
    apply(1'b1, 3'b100, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 5'd18);
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_rd, out_data, out_illegal} !== held) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b rd=%0d d=%h want rdy=0 v=1 rd=%0d d=%h",
                 c, in_ready, out_valid, out_rd, out_data, held.rd, held.data);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_passthru: got in_ready=%b want 1", in_ready);
    end
    r0 = ret_m;
    for (int k = 0; k < 10; k++) begin
      f3 = 3'($urandom_range(0, 7));
      apply(1'b1, f3, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
      step();
      n_chk++;
      if (out_valid !== 1'b1 || exp_q.size() != 1 || {out_rd, out_data, out_illegal} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b rd=%0d d=%h ill=%b want rd=%0d d=%h ill=%b",
                 k, out_valid, out_rd, out_data, out_illegal,
                 (exp_q.size() > 0) ? exp_q[0].rd : 5'd0,
                 (exp_q.size() > 0) ? exp_q[0].data : 32'd0,
                 (exp_q.size() > 0) ? exp_q[0].ill : 1'b0);
      end
    end
    apply(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    step();
    n_chk++;
    // the held entry plus ten streamed ones
    if (retired !== r0 + 32'd11 || retired !== ret_m || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_retired: got ret=%0d v=%b want ret=%0d v=0", retired, out_valid, r0 + 32'd11);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    apply(1'b1, 3'b111, 1'b0, 1'b0, 32'hFFFF_0000, 32'h00FF_FF00, 32'd0, 5'd21);
    step();
    apply(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || retired !== 32'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b ret=%0d rdy=%b want v=0 ret=0 rdy=1", out_valid, retired, in_ready);
    end
    mv = 1'b0; ret_m = 32'd0; exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    apply(1'b1, 3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'd0, 32'h0000_0FE4, 5'd30);
    step();
    apply(1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0030 || out_rd !== 5'd30) begin
      n_fail++;
      $display("FAIL reset_recover: got v=%b d=%h rd=%0d want v=1 d=00000030 rd=30",
               out_valid, out_data, out_rd);
    end
    step();
    n_chk++;
    if (retired !== 32'd1) begin
      n_fail++; $display("FAIL reset_recover_retired: got %0d want 1", retired);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_imm_forms();
    test_illegal_x0();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
